// File: rtl/gpu_mem_pkg.sv
// Shared constants and the per-slot state type for the core request sequencer.
package gpu_mem_pkg;
  localparam int N_CORES    = 16;
  localparam int N_BANKS    = 16;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 8;
  localparam int TIMEOUT    = 255;
  localparam int BANK_HI    = 11;
  localparam int BANK_LO    = 8;
  localparam int BANK_W     = BANK_HI - BANK_LO + 1;
  // Every value the bank field can take; banks at or above N_BANKS read as "no finish".
  localparam int BANK_SLOTS = 1 << BANK_W;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} slot_state_t;
endpackage

// File: rtl/core_req_slot.sv
// One request slot: accepts a request, holds it on the bus until the addressed
// bank finishes (or the timeout expires), then emits a one-cycle response.
module core_req_slot
  import gpu_mem_pkg::*;
#(
  parameter int N_BANKS = gpu_mem_pkg::N_BANKS,
  parameter int TIMEOUT = gpu_mem_pkg::TIMEOUT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                req_valid,
  input  logic                                req_we,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic [DATA_W-1:0]                   req_data,
  output logic                                req_ready,
  output logic                                resp_valid,
  output logic                                resp_err,
  output logic [DATA_W-1:0]                   resp_data,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_data,
  input  logic [BANK_SLOTS-1:0]               fin_by_bank,
  input  logic [BANK_SLOTS-1:0][DATA_W-1:0]   rdata_by_bank
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  slot_state_t         state_reg, state_next;
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                resp_valid_reg, resp_err_reg;
  logic [DATA_W-1:0]   resp_data_reg;
  logic [BANK_W-1:0]   bank;
  logic                fin, accept, bank_bad;

  // Only the finish line of the latched bank matters; others are ignored.
  assign bank     = addr_reg[BANK_HI:BANK_LO];
  assign fin      = fin_by_bank[bank];
  assign accept   = (state_reg == IDLE) && req_valid;
  assign bank_bad = int'(req_addr[BANK_HI:BANK_LO]) >= N_BANKS;

  // Next-state logic: fin takes priority over the timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = bank_bad ? ERR : BUSY;
      BUSY: begin
        if (fin)                        state_next = RESP;
        else if (cnt_reg == CNT_LAST)   state_next = ERR;
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Request latches, BUSY counter and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
      cnt_reg        <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      resp_valid_reg <= (state_next == RESP) || (state_next == ERR);
      resp_err_reg   <= (state_next == ERR);
      resp_data_reg  <= '0;
      if (accept) begin
        we_reg   <= req_we;
        addr_reg <= req_addr;
        data_reg <= req_data;
        cnt_reg  <= '0;
      end else if (state_reg == BUSY) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == BUSY) && fin && !we_reg)
        resp_data_reg <= rdata_by_bank[bank];
    end
  end

  // Bus strobes drop combinationally on the finish cycle so the bank never
  // sees the request again.
  assign req_ready  = (state_reg == IDLE);
  assign mem_read   = (state_reg == BUSY) && !we_reg && !fin;
  assign mem_write  = (state_reg == BUSY) &&  we_reg && !fin;
  assign mem_addr   = addr_reg;
  assign mem_data   = data_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_data  = resp_data_reg;
endmodule

// File: rtl/core_mem_sequencer.sv
// Per-core request sequencer: one core_req_slot per core; this level only
// slices the flat buses and regroups bank finish/data per core.
module core_mem_sequencer
  import gpu_mem_pkg::*;
#(
  parameter int N_BANKS = gpu_mem_pkg::N_BANKS,
  parameter int TIMEOUT = gpu_mem_pkg::TIMEOUT
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [N_CORES-1:0]                  req_valid,
  input  logic [N_CORES-1:0]                  req_we,
  input  logic [N_CORES*ADDR_W-1:0]           req_addr,
  input  logic [N_CORES*DATA_W-1:0]           req_data,
  output logic [N_CORES-1:0]                  req_ready,
  output logic [N_CORES-1:0]                  resp_valid,
  output logic [N_CORES-1:0]                  resp_err,
  output logic [N_CORES*DATA_W-1:0]           resp_data,
  output logic [N_CORES-1:0]                  mem_read,
  output logic [N_CORES-1:0]                  mem_write,
  output logic [N_CORES*ADDR_W-1:0]           mem_addr,
  output logic [N_CORES*DATA_W-1:0]           mem_data,
  input  logic [N_BANKS*N_CORES-1:0]          bank_finish,
  input  logic [N_BANKS*N_CORES*DATA_W-1:0]   bank_rdata
);
  genvar gi, gb;

  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_slot
      logic [BANK_SLOTS-1:0]             fin_by_bank;
      logic [BANK_SLOTS-1:0][DATA_W-1:0] rdata_by_bank;

      // Gather this core's finish bit and data byte from every bank; bank ids
      // that do not exist are tied off.
      for (gb = 0; gb < BANK_SLOTS; gb++) begin : g_bank
        if (gb < N_BANKS) begin : g_real
          assign fin_by_bank[gb]   = bank_finish[gb*N_CORES + gi];
          assign rdata_by_bank[gb] = bank_rdata[(gb*N_CORES + gi)*DATA_W +: DATA_W];
        end else begin : g_absent
          assign fin_by_bank[gb]   = 1'b0;
          assign rdata_by_bank[gb] = '0;
        end
      end

      core_req_slot #(
        .N_BANKS (N_BANKS),
        .TIMEOUT (TIMEOUT)
      ) u_slot (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid[gi]),
        .req_we        (req_we[gi]),
        .req_addr      (req_addr[gi*ADDR_W +: ADDR_W]),
        .req_data      (req_data[gi*DATA_W +: DATA_W]),
        .req_ready     (req_ready[gi]),
        .resp_valid    (resp_valid[gi]),
        .resp_err      (resp_err[gi]),
        .resp_data     (resp_data[gi*DATA_W +: DATA_W]),
        .mem_read      (mem_read[gi]),
        .mem_write     (mem_write[gi]),
        .mem_addr      (mem_addr[gi*ADDR_W +: ADDR_W]),
        .mem_data      (mem_data[gi*DATA_W +: DATA_W]),
        .fin_by_bank   (fin_by_bank),
        .rdata_by_bank (rdata_by_bank)
      );
    end
  endgenerate
endmodule
